// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle sequencer: state encodings, retire counter width, decode helpers.
// Combinational only: no latency, no flow control.
package mc_pkg;

  localparam int RETIRE_W = 32;

  // Encodings 6 and 7 are illegal and recover to FETCH_IDLE.
  typedef enum logic [2:0] {
    FETCH_IDLE = 3'd0,
    FETCH      = 3'd1,
    DECODE     = 3'd2,
    EXEC       = 3'd3,
    MEM        = 3'd4,
    WB         = 3'd5
  } state_e;

  function automatic logic is_mem_op(input logic mrd, input logic mwr);
    return mrd | mwr;
  endfunction

  // Where to go after the PC update cycle: keep fetching only while run is held.
  function automatic state_e after_retire(input logic run);
    return run ? FETCH : FETCH_IDLE;
  endfunction

endpackage

// File: rtl/mc_retire_cnt.sv
// Retired-instruction counter (wraps modulo 2^RETIRE_W); only built with MC_RETIRE_CNT_EN.
// Count visible one cycle after the inc strobe; no backpressure.
`ifdef MC_RETIRE_CNT_EN
module mc_retire_cnt
  import mc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  output logic [RETIRE_W-1:0] count
);

  logic [RETIRE_W-1:0] count_q;
  logic [RETIRE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + RETIRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer; MC_RETIRE_CNT_EN adds a retire counter.
// Latency: ALU 4, load 5, store 4, squash 3 cycles at zero wait; stalls in FETCH/MEM until ready.
module mc_sequencer
  import mc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                RegWR,
  input  logic                MRD,
  input  logic                MWR,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_rd,
  output logic                dmem_rd,
  output logic                dmem_wr,
  output logic                ir_we,
  output logic                flag_we,
  output logic                rf_we,
  output logic                pc_we,
  output logic [2:0]          state,
  output logic                instr_done,
  output logic [RETIRE_W-1:0] retire_cnt
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    imem_rd = 1'b0;
    dmem_rd = 1'b0;
    dmem_wr = 1'b0;
    ir_we   = 1'b0;
    flag_we = 1'b0;
    rf_we   = 1'b0;
    pc_we   = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        if (run) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        imem_rd = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = EXEC;
      end
      EXEC: begin
        flag_we = 1'b1;
        if (is_mem_op(MRD, MWR)) begin
          state_d = MEM;
        end else if (RegWR) begin
          state_d = WB;
        end else begin
          pc_we = 1'b1;
        end
      end
      MEM: begin
        // A simultaneous read+write decode is treated as a store.
        dmem_wr = MWR;
        dmem_rd = MRD & ~MWR;
        if (dmem_ready) begin
          if (RegWR) begin
            state_d = WB;
          end else begin
            pc_we = 1'b1;
          end
        end
      end
      WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase

    if (pc_we) begin
      state_d = after_retire(run);
    end
  end

  assign state      = state_q;
  assign instr_done = pc_we;

`ifdef MC_RETIRE_CNT_EN
  mc_retire_cnt u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_we),
    .count (retire_cnt)
  );
`else
  assign retire_cnt = '0;
`endif

  a_rd_wr_exclusive : assert property (@(posedge clk) disable iff (rst) !(dmem_rd && dmem_wr));
  a_state_legal     : assert property (@(posedge clk) disable iff (rst) state_q inside {FETCH_IDLE, FETCH, DECODE, EXEC, MEM, WB});
  a_single_strobe   : assert property (@(posedge clk) disable iff (rst) $onehot0({ir_we, flag_we, rf_we}));

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL provide ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: run  in  1  permits leaving FETCH_IDLE and starting an instruction.
REQ-004 SHALL provide: RegWR, MRD, MWR  in  1 each  static decode outputs for the instruction currently held in IR.
REQ-005 SHALL provide: imem_ready, dmem_ready  in  1 each  memory completion strobes, one cycle wide.
REQ-006 SHALL provide: imem_rd, dmem_rd, dmem_wr  out  1 each  memory request levels.
REQ-007 SHALL provide: ir_we, flag_we, rf_we, pc_we  out  1 each  single-cycle write strobes for IR, zFlag register, register file and PC.
REQ-008 SHALL provide: state  out  3  current state encoding; instr_done  out  1  equals pc_we.
REQ-009 SHALL provide: retire_cnt  out  32  retired-instruction count (see Configuration).

Function
REQ-010 SHALL implement states: FETCH_IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; encodings 6 and 7 are illegal.
REQ-011 FETCH_IDLE: all outputs 0; advance to FETCH on the next edge when run=1.
REQ-012 FETCH: imem_rd=1 every cycle; when imem_ready=1, ir_we=1 in that same cycle and advance to DECODE; otherwise stay.
REQ-013 DECODE: all strobes 0; unconditional advance to EXEC after exactly 1 cycle.
REQ-014 EXEC: flag_we=1 for 1 cycle; next state MEM if MRD|MWR, else WB if RegWR, else FETCH with pc_we=1 in this cycle.
REQ-015 MEM: dmem_rd=MRD, dmem_wr=MWR held until dmem_ready=1; on dmem_ready: WB if RegWR, else FETCH with pc_we=1 in this cycle.
REQ-016 MEM: if MRD=MWR=1 simultaneously, dmem_wr SHALL take priority and dmem_rd SHALL be 0.
REQ-017 WB: rf_we=1 and pc_we=1 for 1 cycle; advance to FETCH.
REQ-018 Return to FETCH (not FETCH_IDLE) SHALL occur while run=1; when run=0 at the pc_we cycle, the next state SHALL be FETCH_IDLE.
REQ-019 Outputs SHALL be combinational from state and inputs (Mealy strobes ir_we and pc_we); no output SHALL depend on run outside FETCH_IDLE and the pc_we cycle.
REQ-020 Latency: ALU instruction 4 cycles (with zero-wait memory), load 5, store 4, squashed instruction (all decode inputs 0) 3.
REQ-021 An illegal state SHALL force next state FETCH_IDLE with all outputs 0.
REQ-022 imem_ready or dmem_ready asserted outside FETCH or MEM respectively SHALL be ignored.

Reset
REQ-023 rst=1 SHALL immediately force state=FETCH_IDLE, all outputs 0 and retire_cnt=0, including mid-instruction and with pending memory requests.
REQ-024 The first fetch after rst deasserts SHALL begin no earlier than the second rising edge after deassertion with run=1.

Configuration
REQ-025 With macro MC_RETIRE_CNT_EN defined, retire_cnt SHALL increment by 1 (modulo 2^32, wrapping to 0) on every cycle with pc_we=1.
REQ-026 Without MC_RETIRE_CNT_EN, retire_cnt SHALL be constant 0 and contain no counter flops.

Structure
REQ-027 State encodings and the 3-bit state type SHALL live in shared package mc_pkg, with counter width constant RETIRE_W=32.
REQ-028 The retire counter SHALL be sub-module mc_retire_cnt (clk, rst, inc, count), instantiated only under MC_RETIRE_CNT_EN.

Verification
REQ-029 ALU op: run=1, RegWR=1, MRD=MWR=0, imem_ready 1 cycle after request -> states 1,1,2,3,5,1; rf_we and pc_we high together in WB.
REQ-030 Load with 2 wait cycles: MRD=1, RegWR=1, dmem_ready on 3rd MEM cycle -> dmem_rd high 3 cycles, then WB, retire_cnt +1.
REQ-031 Store: MWR=1, RegWR=0, MRD=1 also forced -> dmem_wr=1, dmem_rd=0, pc_we in the dmem_ready cycle, no WB.
REQ-032 Squashed instruction: all decode inputs 0 -> pc_we in EXEC cycle, rf_we never asserted.
REQ-033 rst pulsed during MEM with dmem_wr=1 -> dmem_wr drops in same cycle, state=0, retire_cnt=0.
REQ-034 MC_RETIRE_CNT_EN defined, counter preloaded to 32'hFFFFFFFF via force -> next retire gives 0; undefined build -> retire_cnt stays 0 after 10 retires.
